// File: rtl/cache_stage_1.sv
// Front stage of the 4-way, 16-set, 32-byte-line pipelined cache.
// Registers UFP requests into the stage register, drives the synchronous
// array read address, and owns all array writes (store hits and refills)
// together with the halt/replay sequencing seen by the compare stage.

package cache_stage_1_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [22:0] tag;
    logic [3:0]  set;
    logic [4:0]  offset;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } stage_reg_t;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    STORE  = 3'd1,
    WB     = 3'd2,
    REFILL = 3'd3,
    REPLAY = 3'd4
  } state_t;

endpackage

module cache_stage_1
  import cache_stage_1_pkg::*;
#(
  parameter int WAYS       = 4,
  parameter int SETS       = 16,
  parameter int LINE_BYTES = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               ufp_addr,
  input  logic [3:0]                ufp_rmask,
  input  logic [3:0]                ufp_wmask,
  input  logic [31:0]               ufp_wdata,
  input  logic                      read_halt,
  input  logic                      write_halt,
  input  logic                      dirty_halt,
  input  logic [1:0]                write_way,
  input  logic [2:0]                lru_read,
  input  logic                      dfp_resp,
  input  logic [LINE_BYTES*8-1:0]   dfp_rdata,
  output stage_reg_t                stage_reg,
  output logic [3:0]                array_addr,
  output logic [WAYS-1:0]           data_web,
  output logic [LINE_BYTES-1:0]     data_wmask,
  output logic [LINE_BYTES*8-1:0]   data_din,
  output logic [23:0]               tag_din,
  output logic                      valid_din,
  output logic                      write_done_reg,
  output logic                      dfp_resp_reg,
  output logic                      dfp_switch_reg,
  output logic                      dfp_write_read,
  output logic                      stall
);

  localparam int OFFSET_W = $clog2(LINE_BYTES);
  localparam int SET_W    = $clog2(SETS);
  localparam int WORDS    = LINE_BYTES / 4;

  state_t state;
  logic   any_halt;

  assign any_halt = read_halt | write_halt | dirty_halt;
  assign stall    = (state != RUN) | any_halt;

  // Split a UFP request into the fields the compare stage consumes.
  function automatic stage_reg_t decode_req(input logic [31:0] addr,
                                            input logic [3:0]  rmask,
                                            input logic [3:0]  wmask,
                                            input logic [31:0] wdata);
    stage_reg_t s;
    s.addr   = addr;
    s.tag    = addr[31:OFFSET_W+SET_W];
    s.set    = addr[OFFSET_W +: SET_W];
    s.offset = addr[OFFSET_W-1:0];
    s.rmask  = rmask;
    s.wmask  = wmask;
    s.wdata  = wdata;
    return s;
  endfunction

  // Pseudo-LRU victim: bit0 picks the half, bit1/bit2 pick within it.
  function automatic logic [1:0] plru_victim(input logic [2:0] lru);
    logic [1:0] way;
    if (lru[0]) begin
      way = lru[1] ? 2'd0 : 2'd1;
    end else begin
      way = lru[2] ? 2'd2 : 2'd3;
    end
    return way;
  endfunction

  // Byte-enable mask of a word store placed at its line offset.
  function automatic logic [LINE_BYTES-1:0] store_mask(input logic [3:0] wmask,
                                                       input logic [4:0] offset);
    logic [LINE_BYTES-1:0] m;
    m = {{(LINE_BYTES-4){1'b0}}, wmask} << offset;
    return m;
  endfunction

  // Read address: follow the incoming request only while it can be accepted,
  // otherwise keep re-reading the held set so stage 2 sees consistent data.
  always_comb begin
    array_addr = stage_reg.set;
    if ((state == RUN) && !any_halt) begin
      array_addr = ufp_addr[OFFSET_W +: SET_W];
    end else begin
      array_addr = stage_reg.set;
    end
  end

  // Sequencer: stage register, array write strobes and replay flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      stage_reg      <= '0;
      data_web       <= {WAYS{1'b1}};
      data_wmask     <= {LINE_BYTES{1'b0}};
      data_din       <= {(LINE_BYTES*8){1'b0}};
      tag_din        <= 24'd0;
      valid_din      <= 1'b0;
      write_done_reg <= 1'b0;
      dfp_resp_reg   <= 1'b0;
      dfp_switch_reg <= 1'b0;
      dfp_write_read <= 1'b0;
    end else begin
      // Write strobes last exactly one cycle unless re-armed below.
      data_web       <= {WAYS{1'b1}};
      data_wmask     <= {LINE_BYTES{1'b0}};
      data_din       <= {(LINE_BYTES*8){1'b0}};
      tag_din        <= 24'd0;
      valid_din      <= 1'b0;
      write_done_reg <= 1'b0;
      case (state)
        RUN: begin
          if (!any_halt) begin
            stage_reg <= decode_req(ufp_addr, ufp_rmask, ufp_wmask, ufp_wdata);
          end else if (write_halt) begin
            // Store hit: commit the held store into the hit way, mark dirty.
            state                <= STORE;
            data_web[write_way]  <= 1'b0;
            data_din             <= {WORDS{stage_reg.wdata}};
            data_wmask           <= store_mask(stage_reg.wmask, stage_reg.offset);
            tag_din              <= {1'b1, stage_reg.tag};
            valid_din            <= 1'b1;
            write_done_reg       <= 1'b1;
          end else if (dirty_halt) begin
            state <= WB;
          end else begin
            state <= REFILL;
          end
        end
        STORE: begin
          // The store is done; turn the held request into a bubble.
          stage_reg.rmask <= 4'd0;
          stage_reg.wmask <= 4'd0;
          state           <= RUN;
        end
        WB: begin
          if (dfp_resp) begin
            dfp_switch_reg <= 1'b1;
            state          <= REFILL;
          end else begin
            state <= WB;
          end
        end
        REFILL: begin
          if (dfp_resp) begin
            // Install the fetched line clean in the PLRU victim way.
            data_web[plru_victim(lru_read)] <= 1'b0;
            data_din       <= dfp_rdata;
            data_wmask     <= {LINE_BYTES{1'b1}};
            tag_din        <= {1'b0, stage_reg.tag};
            valid_din      <= 1'b1;
            dfp_resp_reg   <= 1'b1;
            dfp_write_read <= 1'b1;
            dfp_switch_reg <= 1'b0;
            state          <= REPLAY;
          end else begin
            state <= REFILL;
          end
        end
        REPLAY: begin
          dfp_resp_reg   <= 1'b0;
          dfp_write_read <= 1'b0;
          state          <= RUN;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_stage_1.sv
// Randomised bench for cache_stage_1 with a transaction-level reference
// model, plus directed scenarios pinned by hand-computed values.

module tb_cache_stage_1;
  import cache_stage_1_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  ufp_addr;
  logic [3:0]   ufp_rmask;
  logic [3:0]   ufp_wmask;
  logic [31:0]  ufp_wdata;
  logic         read_halt;
  logic         write_halt;
  logic         dirty_halt;
  logic [1:0]   write_way;
  logic [2:0]   lru_read;
  logic         dfp_resp;
  logic [255:0] dfp_rdata;
  stage_reg_t   stage_reg;
  logic [3:0]   array_addr;
  logic [3:0]   data_web;
  logic [31:0]  data_wmask;
  logic [255:0] data_din;
  logic [23:0]  tag_din;
  logic         valid_din;
  logic         write_done_reg;
  logic         dfp_resp_reg;
  logic         dfp_switch_reg;
  logic         dfp_write_read;
  logic         stall;

  int checks = 0;
  int errors = 0;

  cache_stage_1 dut (
    .clk(clk), .rst(rst), .ufp_addr(ufp_addr), .ufp_rmask(ufp_rmask),
    .ufp_wmask(ufp_wmask), .ufp_wdata(ufp_wdata), .read_halt(read_halt),
    .write_halt(write_halt), .dirty_halt(dirty_halt), .write_way(write_way),
    .lru_read(lru_read), .dfp_resp(dfp_resp), .dfp_rdata(dfp_rdata),
    .stage_reg(stage_reg), .array_addr(array_addr), .data_web(data_web),
    .data_wmask(data_wmask), .data_din(data_din), .tag_din(tag_din),
    .valid_din(valid_din), .write_done_reg(write_done_reg),
    .dfp_resp_reg(dfp_resp_reg), .dfp_switch_reg(dfp_switch_reg),
    .dfp_write_read(dfp_write_read), .stall(stall)
  );

  always #5 clk = ~clk;

  // Reference model: phase of the miss/store sequence plus expected outputs.
  localparam int P_IDLE = 0, P_STORE = 1, P_WRITEBACK = 2, P_FETCH = 3, P_REPLAY = 4;
  int           m_phase;
  stage_reg_t   m_stage;
  logic [3:0]   m_web;
  logic [31:0]  m_wmask;
  logic [255:0] m_din;
  logic [23:0]  m_tag;
  logic         m_valid, m_wdone, m_resp, m_switch, m_wr;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int victim_of(input logic [2:0] lru);
    if (lru[0]) return lru[1] ? 0 : 1;
    return lru[2] ? 2 : 3;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_stage = '0; m_web = 4'hF; m_wmask = 32'd0; m_din = 256'd0;
    m_tag = 24'd0; m_valid = 1'b0; m_wdone = 1'b0; m_resp = 1'b0; m_switch = 1'b0; m_wr = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs held before the edge.
  task automatic model_step();
    bit halted;
    int v;
    if (rst) begin
      model_reset();
      return;
    end
    halted = read_halt || write_halt || dirty_halt;
    m_web = 4'hF; m_wmask = 32'd0; m_din = 256'd0; m_tag = 24'd0; m_valid = 1'b0; m_wdone = 1'b0;
    if (m_phase == P_IDLE) begin
      if (!halted) begin
        m_stage.addr = ufp_addr; m_stage.tag = ufp_addr[31:9]; m_stage.set = ufp_addr[8:5];
        m_stage.offset = ufp_addr[4:0]; m_stage.rmask = ufp_rmask; m_stage.wmask = ufp_wmask;
        m_stage.wdata = ufp_wdata;
      end else if (write_halt) begin
        m_phase = P_STORE;
        m_web[write_way] = 1'b0;
        for (int w = 0; w < 8; w++) m_din[w*32 +: 32] = m_stage.wdata;
        for (int b = 0; b < 4; b++)
          if (m_stage.wmask[b] && (int'(m_stage.offset) + b) < 32) m_wmask[int'(m_stage.offset) + b] = 1'b1;
        m_tag = {1'b1, m_stage.tag}; m_valid = 1'b1; m_wdone = 1'b1;
      end else if (dirty_halt) m_phase = P_WRITEBACK;
      else m_phase = P_FETCH;
    end else if (m_phase == P_STORE) begin
      m_stage.rmask = 4'd0; m_stage.wmask = 4'd0; m_phase = P_IDLE;
    end else if (m_phase == P_WRITEBACK) begin
      if (dfp_resp) begin m_switch = 1'b1; m_phase = P_FETCH; end
    end else if (m_phase == P_FETCH) begin
      if (dfp_resp) begin
        v = victim_of(lru_read);
        m_web[v] = 1'b0; m_din = dfp_rdata; m_wmask = 32'hFFFF_FFFF;
        m_tag = {1'b0, m_stage.tag}; m_valid = 1'b1;
        m_resp = 1'b1; m_wr = 1'b1; m_switch = 1'b0; m_phase = P_REPLAY;
      end
    end else begin
      m_resp = 1'b0; m_wr = 1'b0; m_phase = P_IDLE;
    end
  endtask

  task automatic check_comb();
    bit halted;
    halted = read_halt || write_halt || dirty_halt;
    chk("stall", stall, (m_phase != P_IDLE) || halted);
    chk("array_addr", array_addr, ((m_phase == P_IDLE) && !halted) ? ufp_addr[8:5] : m_stage.set);
  endtask

  task automatic check_regs();
    chk("stage_reg", stage_reg, m_stage);
    chk("data_web", data_web, m_web);
    chk("data_wmask", data_wmask, m_wmask);
    chk("data_din", data_din, m_din);
    chk("tag_din", tag_din, m_tag);
    chk("valid_din", valid_din, m_valid);
    chk("write_done_reg", write_done_reg, m_wdone);
    chk("dfp_resp_reg", dfp_resp_reg, m_resp);
    chk("dfp_switch_reg", dfp_switch_reg, m_switch);
    chk("dfp_write_read", dfp_write_read, m_wr);
  endtask

  // One clock: inputs were driven after the falling edge; check both sides.
  task automatic cycle();
    #1; check_comb();
    @(posedge clk); model_step();
    #1; check_regs();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; ufp_addr = 32'd0; ufp_rmask = 4'd0; ufp_wmask = 4'd0; ufp_wdata = 32'd0;
    read_halt = 1'b0; write_halt = 1'b0; dirty_halt = 1'b0; write_way = 2'd0;
    lru_read = 3'd0; dfp_resp = 1'b0; dfp_rdata = 256'd0;
  endtask

  task automatic load(input logic [31:0] a);
    idle_inputs(); ufp_addr = a; ufp_rmask = 4'hF; cycle();
  endtask

  logic [255:0] line;

  initial begin
    model_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    cycle();
    chk("reset_web", data_web, 4'hF);
    chk("reset_rmask", stage_reg.rmask, 4'd0);
    idle_inputs();

    // Load 0x1234: set 1, tag 0x9, offset 0x14.
    load(32'h0000_1234);
    chk("load_array_addr", array_addr, 4'h1);
    chk("load_tag", stage_reg.tag, 23'h000009);
    chk("load_offset", stage_reg.offset, 5'h14);

    // Store hit to way 2.
    idle_inputs(); ufp_addr = 32'h0000_0108; ufp_wmask = 4'h3; ufp_wdata = 32'hDEAD_BEEF; cycle();
    idle_inputs(); write_halt = 1'b1; write_way = 2'd2; cycle();
    chk("store_web", data_web, 4'b1011);
    chk("store_wmask", data_wmask, 32'h0000_0300);
    chk("store_dirty", tag_din[23], 1'b1);
    chk("store_done", write_done_reg, 1'b1);
    idle_inputs(); cycle();
    chk("store_done_once", write_done_reg, 1'b0);
    chk("store_bubble", stage_reg.wmask, 4'd0);

    // Clean miss, victim way1.
    load(32'h2000_0040);
    idle_inputs(); read_halt = 1'b1; cycle();
    line = {8{32'hA5A5_1234}};
    read_halt = 1'b1; lru_read = 3'b001; dfp_resp = 1'b1; dfp_rdata = line; cycle();
    chk("refill_web", data_web, 4'b1101);
    chk("refill_valid", valid_din, 1'b1);
    chk("refill_clean", tag_din[23], 1'b0);
    chk("refill_resp_reg", dfp_resp_reg, 1'b1);
    chk("refill_din", data_din, line);
    idle_inputs(); cycle();
    chk("replay_done", dfp_resp_reg, 1'b0);
    chk("replay_run", stall, 1'b0);

    // Dirty miss: writeback response, then refill response into way3.
    load(32'h0000_0A20);
    idle_inputs(); dirty_halt = 1'b1; cycle();
    idle_inputs(); dfp_resp = 1'b1; cycle();
    chk("wb_switch", dfp_switch_reg, 1'b1);
    chk("wb_no_write", data_web, 4'hF);
    idle_inputs(); cycle();
    chk("wb_switch_held", dfp_switch_reg, 1'b1);
    idle_inputs(); dfp_resp = 1'b1; lru_read = 3'b000; cycle();
    chk("dirty_write_read", dfp_write_read, 1'b1);
    chk("dirty_switch_clr", dfp_switch_reg, 1'b0);
    chk("dirty_web", data_web, 4'b0111);
    idle_inputs(); cycle();

    // Back-to-back loads to sets 3 and 4.
    idle_inputs(); ufp_addr = 32'h0000_0060; ufp_rmask = 4'hF; #1;
    chk("b2b_set3", array_addr, 4'd3);
    chk("b2b_stall3", stall, 1'b0);
    cycle();
    ufp_addr = 32'h0000_0080; #1;
    chk("b2b_set4", array_addr, 4'd4);
    chk("b2b_stall4", stall, 1'b0);
    cycle();

    // Reset during REFILL with a response present: no write may happen.
    load(32'h0000_0100);
    idle_inputs(); read_halt = 1'b1; cycle();
    idle_inputs(); rst = 1'b1; dfp_resp = 1'b1; cycle();
    chk("rst_refill_web", data_web, 4'hF);
    chk("rst_refill_resp", dfp_resp_reg, 1'b0);
    chk("rst_refill_rmask", stage_reg.rmask, 4'd0);
    idle_inputs(); #1;
    chk("rst_refill_run", stall, 1'b0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      rst = ($urandom_range(99) == 0);
      ufp_addr = $urandom;
      ufp_rmask = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom);
      ufp_wmask = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom);
      ufp_wdata = $urandom;
      r = $urandom_range(99);
      write_halt = (r < 6);
      dirty_halt = (r >= 6 && r < 10);
      read_halt = (r >= 10 && r < 16);
      if ($urandom_range(19) == 0) {write_halt, dirty_halt, read_halt} = 3'($urandom);
      write_way = 2'($urandom);
      lru_read = 3'($urandom);
      dfp_resp = ($urandom_range(3) == 0);
      for (int w = 0; w < 8; w++) dfp_rdata[w*32 +: 32] = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
